// File: rtl/skew_buffer.sv
// rtl/skew_buffer.sv - per-lane skew/deskew delay line with valid tracking, stall and flush
// Lane k is delayed k*STEP (skew) or (LN-1-k)*STEP (deskew) enabled cycles.
module skew_buffer #(
    parameter int LW   = 8,
    parameter int LN   = 8,
    parameter int STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LN*LW-1:0] xi,
    input  logic             vi,
    input  logic             en,
    input  logic             dir,
    input  logic             flush,
    output logic [LN*LW-1:0] xo,
    output logic [LN-1:0]    vo,
    output logic             busy
);

    localparam int DEPTH = (LN - 1) * STEP;

    logic [DEPTH-1:0] vld [LN];
    logic [LW-1:0]    dat [LN][DEPTH];
    logic             mode_q;
    logic             mode_eff;
    logic             busy_c;
    logic [LN*LW-1:0] xo_c;
    logic [LN-1:0]    vo_c;

    function automatic int delay_of(input int k, input logic m);
        return m ? (LN - 1 - k) * STEP : k * STEP;
    endfunction

    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k < LN; k++) begin
            busy_c = busy_c | (|vld[k]);
        end
    end

    assign busy = busy_c;
    // Mode is frozen while any beat is in flight so taps never move under data.
    assign mode_eff = busy_c ? mode_q : dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            for (int k = 0; k < LN; k++) begin
                vld[k] <= '0;
                for (int s = 0; s < DEPTH; s++) begin
                    dat[k][s] <= '0;
                end
            end
        end else if (flush) begin
            mode_q <= dir;
            for (int k = 0; k < LN; k++) begin
                vld[k] <= '0;
                for (int s = 0; s < DEPTH; s++) begin
                    dat[k][s] <= '0;
                end
            end
        end else if (en) begin
            mode_q <= mode_eff;
            for (int k = 0; k < LN; k++) begin
                for (int s = DEPTH - 1; s > 0; s--) begin
                    vld[k][s] <= vld[k][s-1];
                    dat[k][s] <= vld[k][s-1] ? dat[k][s-1] : '0;
                end
                if (vi && (delay_of(k, mode_eff) != 0)) begin
                    vld[k][0] <= 1'b1;
                    dat[k][0] <= xi[k*LW +: LW];
                end else begin
                    vld[k][0] <= 1'b0;
                    dat[k][0] <= '0;
                end
            end
        end
    end

    always_comb begin
        xo_c = '0;
        vo_c = '0;
        for (int k = 0; k < LN; k++) begin
            logic          v;
            logic [LW-1:0] d;
            int            dl;
            v  = 1'b0;
            d  = '0;
            dl = delay_of(k, mode_eff);
            if (dl == 0) begin
                v = vi;
                d = xi[k*LW +: LW];
            end else begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (s + 1 == dl) begin
                        v = vld[k][s];
                        d = dat[k][s];
                    end
                end
            end
            // rst_n gating keeps the zero-delay lane quiet during reset too.
            vo_c[k] = v & en & ~flush & rst_n;
            xo_c[k*LW +: LW] = vo_c[k] ? d : '0;
        end
    end

    assign xo = xo_c;
    assign vo = vo_c;

endmodule

// File: tb/tb_skew_buffer.sv
// tb/tb_skew_buffer.sv - randomized scoreboard bench for skew_buffer
module tb_skew_buffer;

    localparam int LW = 8, LN = 4, STEP = 1;
    localparam int DEPTH = (LN - 1) * STEP;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [LN*LW-1:0] xi = '0;
    logic             vi = 1'b0, en = 1'b0, dir = 1'b0, flush = 1'b0;
    logic [LN*LW-1:0] xo;
    logic [LN-1:0]    vo;
    logic             busy;

    always #5 clk = ~clk;

    skew_buffer #(.LW(LW), .LN(LN), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .xi(xi), .vi(vi), .en(en), .dir(dir),
        .flush(flush), .xo(xo), .vo(vo), .busy(busy)
    );

    typedef struct {
        logic [LW-1:0] d;
        int            due;
    } exp_t;

    exp_t lq[LN][$];
    int   issued[$];
    int   tnow = 0;
    logic mq = 1'b0;
    int   cur_tick = 0;
    logic cur_act = 1'b0;
    logic cur_busy = 1'b0;
    bit   mon_on = 1'b0;
    int   total = 0;
    int   bad = 0;

    function automatic int dly(input int k, input logic m);
        return m ? (LN - 1 - k) * STEP : k * STEP;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < LN; k++) lq[k].delete();
        issued.delete();
    endtask

    // One clock cycle of stimulus; the model advances by the spec's rules.
    task automatic cycle(input logic v, input logic e, input logic d, input logic f,
                         input logic [LN*LW-1:0] data);
        logic eff;
        @(negedge clk);
        while (issued.size() > 0 && tnow - issued[0] > DEPTH) void'(issued.pop_front());
        cur_busy = 1'b0;
        foreach (issued[i]) if (tnow - issued[i] >= 1 && tnow - issued[i] <= DEPTH) cur_busy = 1'b1;
        eff = cur_busy ? mq : d;
        vi = v; en = e; dir = d; flush = f; xi = data;
        cur_tick = tnow;
        cur_act = e & ~f;
        if (f) begin
            clear_model();
            mq = d;
        end else if (e) begin
            if (v) begin
                for (int k = 0; k < LN; k++) begin
                    exp_t x;
                    x.d = data[k*LW +: LW];
                    x.due = tnow + dly(k, eff);
                    lq[k].push_back(x);
                end
                issued.push_back(tnow);
            end
            mq = eff;
            tnow++;
        end
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, d, 1'b0, '0);
    endtask

    task automatic do_reset();
        #4;
        rst_n = 1'b0;
        #1;
        check("reset_vo", 32'(vo), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_xo", (xo == '0) ? 32'd1 : 32'd0, 32'd1);
        clear_model();
        mq = 1'b0;
        cur_act = 1'b0;
        cur_busy = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the expected beat of a lane whenever that lane is due.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_on) begin
                for (int k = 0; k < LN; k++) begin
                    logic exp_v;
                    while (lq[k].size() > 0 && lq[k][0].due < cur_tick) void'(lq[k].pop_front());
                    exp_v = cur_act && lq[k].size() > 0 && lq[k][0].due == cur_tick;
                    check($sformatf("vo[%0d]", k), 32'(vo[k]), 32'(exp_v));
                    if (exp_v) begin
                        check($sformatf("xo[%0d]", k), 32'(xo[k*LW +: LW]), 32'(lq[k][0].d));
                        void'(lq[k].pop_front());
                    end else begin
                        check($sformatf("xo_zero[%0d]", k), 32'(xo[k*LW +: LW]), 32'd0);
                    end
                end
                check("busy", 32'(busy), 32'(cur_busy));
            end
        end
    end

    initial begin
        #3;
        check("init_vo", 32'(vo), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        check("init_xo", 32'(xo), 32'd0);
        #4;
        rst_n = 1'b1;
        mon_on = 1'b1;

        cycle(1'b1, 1'b1, 1'b0, 1'b0, {8'd44, 8'd33, 8'd22, 8'd11});
        idle(5, 1'b0);

        cycle(1'b1, 1'b1, 1'b1, 1'b0, {8'd44, 8'd33, 8'd22, 8'd11});
        idle(5, 1'b1);

        for (int c = 0; c < 6; c++) begin
            logic e;
            e = !(c == 2 || c == 3);
            cycle(1'b1, e, 1'b0, 1'b0, {4{8'(8'h10 + c)}});
        end
        idle(6, 1'b0);

        cycle(1'b1, 1'b1, 1'b0, 1'b0, {8'hA4, 8'hA3, 8'hA2, 8'hA1});
        idle(3, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, {8'hB4, 8'hB3, 8'hB2, 8'hB1});
        idle(5, 1'b1);

        cycle(1'b1, 1'b1, 1'b0, 1'b0, {8'd44, 8'd33, 8'd22, 8'd11});
        cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
        idle(5, 1'b0);

        cycle(1'b1, 1'b1, 1'b0, 1'b0, {8'hC4, 8'hC3, 8'hC2, 8'hC1});
        cycle(1'b1, 1'b1, 1'b0, 1'b0, {8'hD4, 8'hD3, 8'hD2, 8'hD1});
        cycle(1'b1, 1'b1, 1'b0, 1'b0, {8'hE4, 8'hE3, 8'hE2, 8'hE1});
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, {8'd44, 8'd33, 8'd22, 8'd11});
        idle(5, 1'b0);

        for (int i = 0; i < 800; i++) begin
            logic rv, re, rd, rf;
            rv = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 4) != 0);
            rd = 1'($urandom_range(0, 1));
            rf = ($urandom_range(0, 24) == 0);
            cycle(rv, re, rd, rf, $urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        idle(8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skew_buffer.md
SKEW_BUFFER -- requirements
Module: skew_buffer

Interface
REQ-001 SHALL have parameter LW, default 8: data bits per lane.
REQ-002 SHALL have parameter LN, default 8: lane count, minimum 2.
REQ-003 SHALL have parameter STEP, default 1: cycles of delay per lane index, minimum 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port xi, input, LN*LW bits: lane k occupies bits [k*LW +: LW].
REQ-007 SHALL have port vi, input, 1 bit: all lanes of xi are valid this cycle.
REQ-008 SHALL have port en, input, 1 bit: advance enable; low stalls the block.
REQ-009 SHALL have port dir, input, 1 bit: requested mode, 0 = skew, 1 = deskew.
REQ-010 SHALL have port flush, input, 1 bit: synchronous clear of in-flight data.
REQ-011 SHALL have port xo, output, LN*LW bits: delayed lanes, same packing as xi.
REQ-012 SHALL have port vo, output, LN bits: per-lane valid for xo.
REQ-013 SHALL have port busy, output, 1 bit: high when any stage register holds a valid beat.

Function
REQ-014 SHALL delay lane k by D(k) = k*STEP enabled cycles in skew mode, and by D(k) = (LN-1-k)*STEP enabled cycles in deskew mode.
REQ-015 SHALL pass a lane with D(k) = 0 combinationally: xo lane = xi lane, vo[k] = vi & en & ~flush.
REQ-016 SHALL carry a valid bit through every stage alongside the data.
REQ-017 SHALL load a stage data register with 0 whenever its incoming valid is 0 (zero-filled bubbles).
REQ-018 SHALL drive 0 on the xo data of any lane whose vo bit is 0.
REQ-019 SHALL define the effective mode as dir when busy = 0, else the registered mode mode_q; mode_q SHALL load the effective mode every cycle.
REQ-020 SHALL therefore ignore any dir change while busy = 1 and apply it on the first cycle busy = 0.
REQ-021 SHALL hold all stage registers, valid bits and mode_q when en = 0 and flush = 0.
REQ-022 SHALL force vo = 0 when en = 0.
REQ-023 SHALL, when en = 1 and flush = 0, shift every lane one stage and capture xi/vi into stage 1 of each lane with D(k) > 0.
REQ-024 SHALL take flush with priority over en: all stage valid and data registers clear to 0 at the next edge, vo = 0 during the flush cycle, and mode_q loads dir.
REQ-025 SHALL size each lane's register chain to (LN-1)*STEP stages and select the output tap at depth D(k); the selection changes only while the buffer is empty.
REQ-026 SHALL derive busy as the OR of all stage valid bits, registered state only, with no dependence on vi.
REQ-027 SHALL drive xo[k] and vo[k] for D(k) > 0 combinationally from the tap at depth D(k), gated by en.
REQ-028 SHALL preserve the beat order within every lane under any pattern of en, and SHALL neither drop nor duplicate beats.

Reset
REQ-029 SHALL, while rst_n = 0, clear every stage data register, valid bit and mode_q to 0, independent of clk.
REQ-030 SHALL drive busy = 0 and vo = 0 while in reset; xo SHALL be 0 on every registered lane.
REQ-031 SHALL, on reset assertion mid-operation, discard in-flight beats; operation SHALL resume in skew mode unless dir = 1 on the first cycle after release.

Verification (LN=4, LW=8, STEP=1, en=1 unless stated; xi written lane3..lane0)
REQ-032 Skew: dir=0, one beat {44,33,22,11} at cycle 0 -> 11 on lane0 at cycle 0, 22 on lane1 at 1, 33 on lane2 at 2, 44 on lane3 at 3; busy high in cycles 1-3; each vo bit high for exactly one cycle.
REQ-033 Deskew: dir=1, same beat -> lane3 at cycle 0, lane2 at 1, lane1 at 2, lane0 at 3.
REQ-034 Stall: stream 4 beats back-to-back with en=0 at cycles 2-3 -> all outputs shift 2 cycles later, data intact, vo=0 during cycles 2-3, no loss or duplication.
REQ-035 Mode lock: dir=0 beat at cycle 0, dir=1 from cycle 1 -> skew timing for the beat; a new beat at cycle 4 (busy=0) uses deskew timing.
REQ-036 Flush: flush=1 at cycle 1 of the REQ-032 beat -> vo=0 at cycle 1, busy=0 from cycle 2, no lane2/lane3 output ever appears.
REQ-037 Reset: rst_n low between edges at cycle 2 of a stream -> immediate vo=0, busy=0, xo registered lanes 0; after release, a fresh skew beat matches REQ-032.
